regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32-entry register file.
- Shares that port between the core writeback path (requester A) and the debug/loader host (requester B) using a req/gnt handshake with round-robin arbitration.
- Runs a clear sequencer that zeroes all 32 registers after reset or on command, and drives the active-low LED status of the last written value.
- Sits between the writeback stage, the debug host and the register file write inputs.

Parameters:
- DATA_W, 32 (equals `SIZE): write data width.
- NREG, 32: number of registers; the address width is 5.
- CLR_VAL, 0: value written to each register during a clear.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_a  input  1  writeback write request.
- addr_a  input  5  writeback destination register.
- data_a  input  DATA_W  writeback data.
- gnt_a  output  1  one-cycle grant to A.
- req_b  input  1  debug host write request.
- addr_b  input  5  debug destination register.
- data_b  input  DATA_W  debug data.
- gnt_b  output  1  one-cycle grant to B.
- clear_req  input  1  pulse; starts a full register clear.
- busy  output  1  high while clearing.
- clear_done  output  1  one-cycle pulse when a clear completes.
- rf_we  output  1  register file write enable.
- rf_waddr  output  5  register file write address.
- rf_wdata  output  DATA_W  register file write data.
- led_n  output  4  ~(last rf_wdata[3:0] written with rf_we=1).

Behaviour:
- Reset: one clock, synchronous, active-low; applied on any edge with rst_n=0.
- Values while and immediately after reset:
  - gnt_a=gnt_b=0, rf_we=0, rf_waddr=0, rf_wdata=0, clear_done=0.
  - led_n=4'hF; busy=1, because the FSM enters CLEAR with idx=0.
  - Round-robin pointer gives A priority.
- FSM states: CLEAR and ARB.
- CLEAR:
  - Each cycle registers rf_we=1, rf_waddr=idx, rf_wdata=CLR_VAL, then idx++.
  - After idx=NREG-1 has been issued, the FSM moves to ARB and clear_done pulses for one cycle, coincident with the final write.
  - A clear therefore takes exactly NREG cycles of rf_we.
  - No grants are issued in CLEAR; requests stay pending.
  - clear_req is ignored in CLEAR.
- ARB:
  - clear_req=1 moves to CLEAR (idx=0) on the next edge; no grant is issued that cycle.
  - Eligible requester: req=1 and its gnt is not currently high (max one grant per requester every 2 cycles).
  - One eligible requester: grant it.
  - Both eligible: grant the one not granted last.
  - The pointer updates only on a grant.
- Grant timing:
  - A request sampled at edge N yields, during cycle N+1, gnt_x=1 together with rf_we, rf_waddr=addr_x, rf_wdata=data_x.
  - Latency is 1 cycle; all outputs are registered.
- Handshake:
  - Requester holds req/addr/data stable until it sees gnt.
  - It may drop req or present a new request in the gnt cycle.
- Address 0:
  - A grant to addr 0 still pulses gnt, but forces rf_we=0 (register 0 stays hardwired zero).
  - led_n is unchanged.
  - CLEAR does write register 0 with CLR_VAL.
- led_n updates only on cycles where rf_we=1 is issued.
- Reset mid-clear or mid-grant: everything restarts from the reset state, and the clear restarts from idx=0.
- With no request, rf_we=0 and rf_waddr/rf_wdata hold their previous values.

Optional Feature:
- Macro: WRARB_STATS_EN.
- Defined:
  - Adds outputs cnt_a and cnt_b (16 bits each): saturating counts of gnt_a and gnt_b pulses.
  - Both counters hold at 16'hFFFF once saturated and reset to 0 under rst_n.
  - Clear writes are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then release -> busy=1 for 32 cycles; rf_we=1 with rf_waddr 0..31 and rf_wdata=0; clear_done pulses with rf_waddr=31; led_n=4'hF.
- After clear, req_a with addr_a=5, data_a=0x1234 -> next cycle gnt_a=1, rf_we=1, rf_waddr=5, rf_wdata=0x1234, led_n=4'hB.
- req_a and req_b held continuously with different addresses -> grants alternate A,B,A,B; never two consecutive grants to the same requester.
- req_b with addr_b=0, data_b=0xF -> gnt_b=1, rf_we=0, led_n unchanged.
- clear_req during ARB while req_a is pending -> 32 clear writes, no gnt_a until clear_done, then gnt_a on the following cycle.
- rst_n low at clear idx=10 -> after release, clear restarts at idx=0; with WRARB_STATS_EN, cnt_a=cnt_b=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - write-port owner for the 32-entry register file with round-robin arbitration and clear sequencer
// Optional grant statistics (cnt_a/cnt_b) are built when WRARB_STATS_EN is defined.
module regfile_write_arbiter #(
  parameter int                 DATA_W  = 32,
  parameter int                 NREG    = 32,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [4:0]        addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [4:0]        addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        led_n
`ifdef WRARB_STATS_EN
  ,
  output logic [15:0]       cnt_a,
  output logic [15:0]       cnt_b
`endif
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              ptr_b_q, ptr_b_d;  // 1: B wins a tie next time
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              clear_done_q, clear_done_d;
  logic [3:0]        led_n_q, led_n_d;

  logic              elig_a, elig_b;
  logic              grant_a, grant_b;

  // Next-state and registered-output logic for the CLEAR/ARB sequencer
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_b_d      = ptr_b_q;
    gnt_a_d      = 1'b0;
    gnt_b_d      = 1'b0;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    clear_done_d = 1'b0;
    led_n_d      = led_n_q;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    // A requester that holds a grant this cycle sits out one round.
    elig_a       = req_a && !gnt_a_q;
    elig_b       = req_b && !gnt_b_q;

    case (state_q)
      ST_CLEAR: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = idx_q;
        rf_wdata_d = CLR_VAL;
        led_n_d    = ~CLR_VAL[3:0];
        if (idx_q == LAST_IDX) begin
          state_d      = ST_ARB;
          idx_d        = 5'd0;
          clear_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_ARB: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = 5'd0;
        end else begin
          if (elig_a && (!elig_b || !ptr_b_q)) begin
            grant_a = 1'b1;
          end else if (elig_b) begin
            grant_b = 1'b1;
          end

          if (grant_a) begin
            gnt_a_d    = 1'b1;
            rf_waddr_d = addr_a;
            rf_wdata_d = data_a;
            rf_we_d    = (addr_a != 5'd0);
            ptr_b_d    = 1'b1;
          end else if (grant_b) begin
            gnt_b_d    = 1'b1;
            rf_waddr_d = addr_b;
            rf_wdata_d = data_b;
            rf_we_d    = (addr_b != 5'd0);
            ptr_b_d    = 1'b0;
          end

          // Register 0 is hardwired zero: its grants write nothing and leave the LEDs alone.
          if (rf_we_d) begin
            led_n_d = ~rf_wdata_d[3:0];
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = 5'd0;
      end
    endcase
  end

  // State and output registers; reset re-enters CLEAR from register 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      idx_q        <= 5'd0;
      ptr_b_q      <= 1'b0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= '0;
      clear_done_q <= 1'b0;
      led_n_q      <= 4'hF;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_b_q      <= ptr_b_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      clear_done_q <= clear_done_d;
      led_n_q      <= led_n_d;
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign busy       = (state_q == ST_CLEAR);
  assign clear_done = clear_done_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign led_n      = led_n_q;

`ifdef WRARB_STATS_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;

  // Saturating grant counters; clear writes never count
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (grant_a && (cnt_a_q != 16'hFFFF)) cnt_a_d = cnt_a_q + 16'd1;
    if (grant_b && (cnt_b_q != 16'hFFFF)) cnt_b_d = cnt_b_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a_q <= 16'd0;
      cnt_b_q <= 16'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and randomized checks of regfile_write_arbiter against a behavioural model
module tb_regfile_write_arbiter;

  localparam int DW   = 32;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n, req_a, req_b, clear_req;
  logic [4:0]    addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b, busy, clear_done, rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [3:0]    led_n;
`ifdef WRARB_STATS_EN
  logic [15:0]   cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DW), .NREG(NREG), .CLR_VAL('0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (req_a),
    .addr_a     (addr_a),
    .data_a     (data_a),
    .gnt_a      (gnt_a),
    .req_b      (req_b),
    .addr_b     (addr_b),
    .data_b     (data_b),
    .gnt_b      (gnt_b),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .led_n      (led_n)
`ifdef WRARB_STATS_EN
    ,
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: clear progress as "writes still owed", tie-break as "who won last".
  int            m_clear_left;
  bit            m_last_was_a;
  int            m_cnt_a, m_cnt_b;
  logic          e_gnt_a, e_gnt_b, e_we, e_done;
  logic [4:0]    e_waddr;
  logic [DW-1:0] e_wdata;
  logic [3:0]    e_led;

  task automatic model_step();
    bit ea, eb, ga, gb;
    ga     = 1'b0;
    gb     = 1'b0;
    e_we   = 1'b0;
    e_done = 1'b0;
    if (!rst_n) begin
      m_clear_left = NREG;
      m_last_was_a = 1'b0;
      m_cnt_a      = 0;
      m_cnt_b      = 0;
      e_gnt_a      = 1'b0;
      e_gnt_b      = 1'b0;
      e_waddr      = '0;
      e_wdata      = '0;
      e_led        = 4'hF;
      return;
    end
    if (m_clear_left > 0) begin
      e_we    = 1'b1;
      e_waddr = 5'(NREG - m_clear_left);
      e_wdata = '0;
      m_clear_left--;
      e_done  = (m_clear_left == 0);
    end else if (clear_req) begin
      m_clear_left = NREG;
    end else begin
      ea = req_a && !e_gnt_a;
      eb = req_b && !e_gnt_b;
      if (ea && eb) begin
        ga = !m_last_was_a;
        gb = m_last_was_a;
      end else begin
        ga = ea;
        gb = eb;
      end
      if (ga) begin
        e_waddr      = addr_a;
        e_wdata      = data_a;
        m_last_was_a = 1'b1;
        if (m_cnt_a < 65535) m_cnt_a++;
      end
      if (gb) begin
        e_waddr      = addr_b;
        e_wdata      = data_b;
        m_last_was_a = 1'b0;
        if (m_cnt_b < 65535) m_cnt_b++;
      end
      e_we = (ga || gb) && (e_waddr != 5'd0);
    end
    e_gnt_a = ga;
    e_gnt_b = gb;
    if (e_we) e_led = ~e_wdata[3:0];
  endtask

  task automatic compare_all();
    check_eq("gnt_a", gnt_a, e_gnt_a);
    check_eq("gnt_b", gnt_b, e_gnt_b);
    check_eq("rf_we", rf_we, e_we);
    check_eq("rf_waddr", rf_waddr, e_waddr);
    check_eq("rf_wdata", rf_wdata, e_wdata);
    check_eq("clear_done", clear_done, e_done);
    check_eq("busy", busy, (m_clear_left > 0));
    check_eq("led_n", led_n, e_led);
`ifdef WRARB_STATS_EN
    check_eq("cnt_a", cnt_a, m_cnt_a);
    check_eq("cnt_b", cnt_b, m_cnt_b);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int we_cycles, who, prev, seen_gnt;
    bit done_seen;
    logic [3:0] led_before;

    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; clear_req = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    m_clear_left = NREG; m_last_was_a = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    e_gnt_a = 1'b0; e_gnt_b = 1'b0; e_we = 1'b0; e_done = 1'b0;
    e_waddr = '0; e_wdata = '0; e_led = 4'hF;

    // Reset, then the power-on clear
    tick();
    tick();
    check_eq("reset_busy", busy, 1'b1);
    check_eq("reset_led", led_n, 4'hF);
    rst_n = 1'b1;
    we_cycles = 0;
    for (int i = 0; i < NREG; i++) begin
      tick();
      if (rf_we) we_cycles++;
    end
    check_eq("clear_writes", we_cycles, NREG);
    check_eq("clear_last_addr", rf_waddr, 5'd31);
    check_eq("clear_done_pulse", clear_done, 1'b1);
    check_eq("clear_busy_off", busy, 1'b0);

    // Single writeback grant
    req_a = 1'b1; addr_a = 5'd5; data_a = 32'h1234;
    tick();
    check_eq("wb_gnt_a", gnt_a, 1'b1);
    check_eq("wb_addr", rf_waddr, 5'd5);
    check_eq("wb_data", rf_wdata, 32'h1234);
    check_eq("wb_led", led_n, 4'hB);
    req_a = 1'b0;
    tick();

    // Both requesters held: grants must alternate
    req_a = 1'b1; addr_a = 5'd3; data_a = $urandom;
    req_b = 1'b1; addr_b = 5'd7; data_b = $urandom;
    prev = 2;
    for (int i = 0; i < 8; i++) begin
      tick();
      who = gnt_a ? 0 : (gnt_b ? 1 : 2);
      check_eq("alt_one_grant", int'(gnt_a) + int'(gnt_b), 1);
      if (i > 0) check_eq("alt_switch", (who == prev), 1'b0);
      prev = who;
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    tick();

    // Debug write to register 0
    led_before = e_led;
    req_b = 1'b1; addr_b = 5'd0; data_b = 32'hF;
    tick();
    check_eq("r0_gnt_b", gnt_b, 1'b1);
    check_eq("r0_we", rf_we, 1'b0);
    check_eq("r0_led", led_n, led_before);
    req_b = 1'b0;
    tick();

    // Clear requested while A is pending
    req_a = 1'b1; addr_a = 5'd9; data_a = 32'hABCD;
    clear_req = 1'b1;
    tick();
    check_eq("clr_no_gnt", gnt_a, 1'b0);
    check_eq("clr_busy", busy, 1'b1);
    clear_req = 1'b0;
    seen_gnt = 0; done_seen = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      tick();
      if (gnt_a) seen_gnt++;
      if (clear_done) done_seen = 1'b1;
    end
    check_eq("clr_done_seen", done_seen, 1'b1);
    check_eq("clr_gnt_during", seen_gnt, 0);
    tick();
    check_eq("clr_gnt_after", gnt_a, 1'b1);
    check_eq("clr_gnt_addr", rf_waddr, 5'd9);
    req_a = 1'b0;
    tick();

    // Reset in the middle of a clear (next index 10)
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("midclr_addr9", rf_waddr, 5'd9);
    rst_n = 1'b0;
    tick();
`ifdef WRARB_STATS_EN
    check_eq("midclr_cnt_a", cnt_a, 16'd0);
    check_eq("midclr_cnt_b", cnt_b, 16'd0);
`endif
    rst_n = 1'b1;
    tick();
    check_eq("midclr_restart_we", rf_we, 1'b1);
    check_eq("midclr_restart_addr", rf_waddr, 5'd0);

    // Randomized traffic obeying the hold-until-grant handshake
    for (int i = 0; i < 3000; i++) begin
      if (!req_a || e_gnt_a) begin
        req_a  = ($urandom_range(0, 2) != 0);
        addr_a = 5'($urandom);
        data_a = $urandom;
      end
      if (!req_b || e_gnt_b) begin
        req_b  = ($urandom_range(0, 2) != 0);
        addr_b = 5'($urandom);
        data_b = $urandom;
      end
      clear_req = ($urandom_range(0, 63) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
